// File: rtl/bp_resolve_unit.sv
// Fetch-PC sequencer plus an in-order FIFO of in-flight predictions. It checks each
// resolved instruction against its recorded prediction, redirects and flushes on a mismatch, and issues predictor updates.
module bp_resolve_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        stall,
  output logic [31:0] current_PC,
  input  logic [31:0] predicted_PC,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_taken,
  input  logic [31:0] ex_PC,
  input  logic [31:0] ex_target,
  output logic        Wr_enable,
  output logic        is_taken,
  output logic [31:0] update_PC,
  output logic [31:0] update_target_PC,
  output logic        flush,
  output logic        full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      pc_reg;
  logic [31:0]      pred_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic        resolve;
  logic        mispredict;
  logic        fetch_en;
  logic        pop;
  logic [31:0] actual_next;

  // Only the predicted next PC of each entry is kept. Resolution compares against
  // ex_PC/ex_target, so the fetch PC half of the pushed pair is never read back.
  assign current_PC  = pc_reg;
  assign full        = (count == CNT_W'(DEPTH));
  assign resolve     = ex_valid && (count != '0);
  assign actual_next = (ex_is_branch && ex_taken) ? ex_target : ex_PC + 32'd4;
  assign mispredict  = resolve && (pred_mem[rd_ptr] != actual_next);
  assign fetch_en    = !stall && !full && !mispredict;
  assign pop         = resolve && !mispredict;

  always_ff @(posedge CLK) begin
    if (fetch_en) begin
      pred_mem[wr_ptr] <= predicted_PC;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_reg <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      flush  <= 1'b0;
    end else begin
      flush <= mispredict;
      if (mispredict) begin
        pc_reg <= actual_next;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (fetch_en) begin
          pc_reg <= predicted_PC;
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({fetch_en, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // A non-branch that was predicted taken writes not-taken, which clears the stale entry.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      Wr_enable        <= 1'b0;
      is_taken         <= 1'b0;
      update_PC        <= '0;
      update_target_PC <= '0;
    end else if (resolve && (ex_is_branch || mispredict)) begin
      Wr_enable        <= 1'b1;
      is_taken         <= ex_is_branch && ex_taken;
      update_PC        <= ex_PC;
      update_target_PC <= ex_target;
    end else begin
      Wr_enable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bp_resolve_unit.sv
// Directed testbench for bp_resolve_unit: sequential fetch, correct and mispredicted
// resolutions, full-FIFO behaviour and mid-flight reset, against hand-computed values.
module tb_bp_resolve_unit;

  logic        CLK;
  logic        nRST;
  logic        stall;
  logic [31:0] current_PC;
  logic [31:0] predicted_PC;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_PC;
  logic [31:0] ex_target;
  logic        Wr_enable;
  logic        is_taken;
  logic [31:0] update_PC;
  logic [31:0] update_target_PC;
  logic        flush;
  logic        full;

  logic        use_seq;
  logic [31:0] pred_value;
  int          assert_count;
  int          fail_count;

  bp_resolve_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .stall            (stall),
    .current_PC       (current_PC),
    .predicted_PC     (predicted_PC),
    .ex_valid         (ex_valid),
    .ex_is_branch     (ex_is_branch),
    .ex_taken         (ex_taken),
    .ex_PC            (ex_PC),
    .ex_target        (ex_target),
    .Wr_enable        (Wr_enable),
    .is_taken         (is_taken),
    .update_PC        (update_PC),
    .update_target_PC (update_target_PC),
    .flush            (flush),
    .full             (full)
  );

  // Predictor stand-in: either a sequential next-PC or a bench-chosen value.
  assign predicted_PC = use_seq ? current_PC + 32'd4 : pred_value;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic br, input logic tk,
                               input logic [31:0] pc, input logic [31:0] tgt);
    ex_valid     = valid;
    ex_is_branch = br;
    ex_taken     = tk;
    ex_PC        = pc;
    ex_target    = tgt;
  endtask

  initial begin
    assert_count = 0;
    fail_count   = 0;
    nRST         = 1'b0;
    stall        = 1'b0;
    use_seq      = 1'b1;
    pred_value   = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    #2;
    checkOutput("rst_pc", current_PC, 32'h0);
    checkOutput("rst_full", {31'b0, full}, 32'h0);
    checkOutput("rst_flush", {31'b0, flush}, 32'h0);
    checkOutput("rst_wr", {31'b0, Wr_enable}, 32'h0);
    checkOutput("rst_taken", {31'b0, is_taken}, 32'h0);
    checkOutput("rst_upc", update_PC, 32'h0);
    checkOutput("rst_utgt", update_target_PC, 32'h0);

    @(negedge CLK);
    nRST = 1'b1;

    // Sequential fetch until the four-entry FIFO fills
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput("seq_pc", current_PC, 32'(i * 4));
      checkOutput("seq_full", {31'b0, full}, (i == 4) ? 32'h1 : 32'h0);
    end
    tick();
    checkOutput("full_hold_pc", current_PC, 32'h10);
    checkOutput("full_hold_full", {31'b0, full}, 32'h1);

    // Correct resolve of head {0,4} while full: pop only, then push resumes
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("pop_full", {31'b0, full}, 32'h0);
    checkOutput("pop_pc", current_PC, 32'h10);
    checkOutput("pop_flush", {31'b0, flush}, 32'h0);
    checkOutput("pop_wr", {31'b0, Wr_enable}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("refill_pc", current_PC, 32'h14);
    checkOutput("refill_full", {31'b0, full}, 32'h1);

    // Resolutions continue under stall; a correctly predicted branch still updates
    stall = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    tick();
    checkOutput("stall_pop_full", {31'b0, full}, 32'h0);
    checkOutput("stall_pop_wr", {31'b0, Wr_enable}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'hC, 32'h100);
    tick();
    checkOutput("nt_br_wr", {31'b0, Wr_enable}, 32'h1);
    checkOutput("nt_br_upc", update_PC, 32'hC);
    checkOutput("nt_br_utgt", update_target_PC, 32'h100);
    checkOutput("nt_br_taken", {31'b0, is_taken}, 32'h0);
    checkOutput("nt_br_flush", {31'b0, flush}, 32'h0);
    checkOutput("nt_br_pc", current_PC, 32'h14);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("idle_wr", {31'b0, Wr_enable}, 32'h0);
    checkOutput("idle_upc_hold", update_PC, 32'hC);

    // Taken mispredict on head {0x10,0x14}
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h10, 32'h40);
    tick();
    checkOutput("tk_mp_pc", current_PC, 32'h40);
    checkOutput("tk_mp_flush", {31'b0, flush}, 32'h1);
    checkOutput("tk_mp_full", {31'b0, full}, 32'h0);
    checkOutput("tk_mp_wr", {31'b0, Wr_enable}, 32'h1);
    checkOutput("tk_mp_upc", update_PC, 32'h10);
    checkOutput("tk_mp_utgt", update_target_PC, 32'h40);
    checkOutput("tk_mp_taken", {31'b0, is_taken}, 32'h1);

    // ex_valid with an empty FIFO right after a flush is ignored
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h99, 32'h200);
    tick();
    checkOutput("empty_pc", current_PC, 32'h40);
    checkOutput("empty_flush", {31'b0, flush}, 32'h0);
    checkOutput("empty_wr", {31'b0, Wr_enable}, 32'h0);
    checkOutput("empty_upc_hold", update_PC, 32'h10);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Build head {0x20,0x80} behind a {0x40,0x20} entry
    stall      = 1'b0;
    use_seq    = 1'b0;
    pred_value = 32'h20;
    tick();
    checkOutput("redir_pc1", current_PC, 32'h20);
    pred_value = 32'h80;
    tick();
    checkOutput("redir_pc2", current_PC, 32'h80);
    stall = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h40, 32'h20);
    tick();
    checkOutput("tk_ok_wr", {31'b0, Wr_enable}, 32'h1);
    checkOutput("tk_ok_taken", {31'b0, is_taken}, 32'h1);
    checkOutput("tk_ok_upc", update_PC, 32'h40);
    checkOutput("tk_ok_flush", {31'b0, flush}, 32'h0);

    // Non-branch predicted taken: redirect to ex_PC+4, write not-taken
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h20, 32'h1234);
    tick();
    checkOutput("nb_mp_pc", current_PC, 32'h24);
    checkOutput("nb_mp_flush", {31'b0, flush}, 32'h1);
    checkOutput("nb_mp_wr", {31'b0, Wr_enable}, 32'h1);
    checkOutput("nb_mp_taken", {31'b0, is_taken}, 32'h0);
    checkOutput("nb_mp_upc", update_PC, 32'h20);
    checkOutput("nb_mp_utgt", update_target_PC, 32'h1234);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("nb_flush_drop", {31'b0, flush}, 32'h0);

    // Reset mid-flight with three entries and an update about to be issued
    stall   = 1'b0;
    use_seq = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("mid_pc", current_PC, 32'h30);
    stall = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h24, 32'h500);
    #2;
    nRST = 1'b0;
    #1;
    checkOutput("mid_rst_pc", current_PC, 32'h0);
    checkOutput("mid_rst_full", {31'b0, full}, 32'h0);
    checkOutput("mid_rst_wr", {31'b0, Wr_enable}, 32'h0);
    checkOutput("mid_rst_flush", {31'b0, flush}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    nRST = 1'b1;
    tick();
    checkOutput("post_rst_wr", {31'b0, Wr_enable}, 32'h0);
    checkOutput("post_rst_pc", current_PC, 32'h0);
    stall = 1'b0;
    tick();
    checkOutput("post_rst_push", current_PC, 32'h4);
    checkOutput("post_rst_wr2", {31'b0, Wr_enable}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
